// File: rtl/baud_gen_pkg.sv
// Shared constants, edge-priority decode and elaboration helpers for baud_gen.
package baud_gen_pkg;

  localparam int          DEFAULT_WIDTH      = 16;
  localparam int          DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DIV        = 32'h0000_0067;

  // Divisors for a 12 MHz system clock at OVERSAMPLE = 16
  localparam int unsigned BAUD_DIV_12M_115200 = 6;
  localparam int unsigned BAUD_DIV_12M_9600   = 77;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_RESYNC,
    ACT_LOAD,
    ACT_IDLE,
    ACT_COUNT
  } edge_act_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic edge_act_e edge_action(input logic rst_n, input logic resync,
                                            input logic div_load, input logic enable);
    if (!rst_n)        return ACT_RESET;
    else if (resync)   return ACT_RESYNC;
    else if (div_load) return ACT_LOAD;
    else if (!enable)  return ACT_IDLE;
    else               return ACT_COUNT;
  endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Loadable divisor register and prescaler producing the oversample tick.
module baud_prescaler #(
  parameter int          WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 32'h67
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             resync,
  output logic             tick,
  output logic             os_pulse
);
  import baud_gen_pkg::*;

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] cnt_q;
  edge_act_e        act;

  // tick marks an edge on which the prescaler wraps; the top uses it to step the phase
  always_comb begin
    act  = edge_action(rst_n, resync, div_load, enable);
    tick = (act == ACT_COUNT) && (cnt_q == div_q);
  end

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        div_q    <= WIDTH'(DEFAULT_DIV);
        cnt_q    <= '0;
        os_pulse <= 1'b0;
      end
      ACT_RESYNC: begin
        if (div_load) div_q <= div_in;
        cnt_q    <= '0;
        os_pulse <= 1'b0;
      end
      ACT_LOAD: begin
        div_q    <= div_in;
        cnt_q    <= '0;
        os_pulse <= 1'b0;
      end
      ACT_COUNT: begin
        if (tick) begin
          cnt_q    <= '0;
          os_pulse <= 1'b1;
        end else begin
          cnt_q    <= cnt_q + WIDTH'(1);
          os_pulse <= 1'b0;
        end
      end
      default: begin
        cnt_q    <= '0;
        os_pulse <= 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/baud_gen.sv
// Programmable baud generator: prescaler tick divided by OVERSAMPLE into new_clk.
module baud_gen #(
  parameter int          WIDTH       = baud_gen_pkg::DEFAULT_WIDTH,
  parameter int          OVERSAMPLE  = baud_gen_pkg::DEFAULT_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV = baud_gen_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             resync,
  output logic             os_pulse,
  output logic             new_clk,
  output logic             clk_pulse
);
  import baud_gen_pkg::*;

  localparam int            PW   = clog2(OVERSAMPLE);
  localparam logic [PW-1:0] HALF = PW'(OVERSAMPLE / 2);

  generate
    if (!is_pow2(OVERSAMPLE) || OVERSAMPLE < 2) begin : g_bad_oversample
      $error("baud_gen: OVERSAMPLE must be a power of two and at least 2");
    end
  endgenerate

  logic          tick;
  logic [PW-1:0] ph_q;
  logic [PW-1:0] ph_next;
  edge_act_e     act;

  baud_prescaler #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_in   (div_in),
    .div_load (div_load),
    .resync   (resync),
    .tick     (tick),
    .os_pulse (os_pulse)
  );

  // ph wraps naturally at OVERSAMPLE because its width is exactly log2(OVERSAMPLE)
  always_comb begin
    act     = edge_action(rst_n, resync, div_load, enable);
    ph_next = ph_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_RESYNC, ACT_IDLE: begin
        ph_q      <= '0;
        new_clk   <= 1'b0;
        clk_pulse <= 1'b0;
      end
      ACT_LOAD: begin
        clk_pulse <= 1'b0;
      end
      ACT_COUNT: begin
        if (tick) begin
          ph_q      <= ph_next;
          new_clk   <= (ph_next >= HALF);
          clk_pulse <= (ph_next == HALF);
        end else begin
          clk_pulse <= 1'b0;
        end
      end
      default: begin
        ph_q      <= '0;
        new_clk   <= 1'b0;
        clk_pulse <= 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_baud_gen.sv
// Directed scoreboard bench for baud_gen across three parameter sets.
module tb_baud_gen;

  localparam int S_NONE = -1;
  localparam int A_OS = 0, A_NC = 1, A_CP = 2;
  localparam int B_OS = 3, B_NC = 4, B_CP = 5;
  localparam int C_OS = 6, C_NC = 7, C_CP = 8;

  logic        clk = 1'b0;
  logic        rst_n, enable, div_load, resync;
  logic [15:0] div_in_a;
  logic [7:0]  div_in_b;
  logic [3:0]  div_in_c;
  logic        a_os, a_nc, a_cp;
  logic        b_os, b_nc, b_cp;
  logic        c_os, c_nc, c_cp;

  int checks = 0;
  int errors = 0;
  int q1[$];
  int q2[$];
  int q3[$];

  always #5 clk = ~clk;

  baud_gen u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div_in(div_in_a),
    .div_load(div_load), .resync(resync),
    .os_pulse(a_os), .new_clk(a_nc), .clk_pulse(a_cp)
  );

  baud_gen #(.WIDTH(8), .OVERSAMPLE(4), .DEFAULT_DIV(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div_in(div_in_b),
    .div_load(div_load), .resync(resync),
    .os_pulse(b_os), .new_clk(b_nc), .clk_pulse(b_cp)
  );

  baud_gen #(.WIDTH(4), .OVERSAMPLE(2), .DEFAULT_DIV(15)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div_in(div_in_c),
    .div_load(div_load), .resync(resync),
    .os_pulse(c_os), .new_clk(c_nc), .clk_pulse(c_cp)
  );

  function automatic logic sig(input int s);
    case (s)
      A_OS: return a_os;
      A_NC: return a_nc;
      A_CP: return a_cp;
      B_OS: return b_os;
      B_NC: return b_nc;
      B_CP: return b_cp;
      C_OS: return c_os;
      C_NC: return c_nc;
      C_CP: return c_cp;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = A_OS; s <= C_CP; s++) chk($sformatf("%s_sig%0d", tag, s), {31'd0, sig(s)}, 0);
  endtask

  // Runs n cycles; pulses on s1/s2 and level changes on s3 pop the matching queue
  task automatic watch(input int s1, input int s2, input int s3, input int n, input string tag);
    logic prev;
    int   e;
    prev = sig(s3);
    for (int k = 1; k <= n; k++) begin
      step();
      if (s1 != S_NONE && sig(s1) === 1'b1) begin
        e = (q1.size() > 0) ? q1.pop_front() : -1;
        chk({tag, "_p1"}, k, e);
      end
      if (s2 != S_NONE && sig(s2) === 1'b1) begin
        e = (q2.size() > 0) ? q2.pop_front() : -1;
        chk({tag, "_p2"}, k, e);
      end
      if (s3 != S_NONE && sig(s3) !== prev) begin
        e = (q3.size() > 0) ? q3.pop_front() : -1;
        chk({tag, "_edge"}, k, e);
        prev = sig(s3);
      end
    end
    chk({tag, "_p1_left"}, q1.size(), 0);
    chk({tag, "_p2_left"}, q2.size(), 0);
    chk({tag, "_edge_left"}, q3.size(), 0);
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    enable   = 1'b0;
    div_load = 1'b0;
    resync   = 1'b0;
    div_in_a = 16'h0067;
    div_in_b = 8'd2;
    div_in_c = 4'd15;

    // reset for 3 cycles, then defaults: D=0x67 -> os_pulse every 104
    repeat (3) begin
      step();
      chk_all_zero("reset");
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    q1.push_back(104);
    q1.push_back(208);
    watch(A_OS, A_CP, S_NONE, 210, "default");

    // basic divide D=2, OVERSAMPLE=4 after resync+load
    div_in_b = 8'd2;
    resync   = 1'b1;
    div_load = 1'b1;
    step();
    chk("load_os", {31'd0, b_os}, 0);
    chk("load_nc", {31'd0, b_nc}, 0);
    chk("load_cp", {31'd0, b_cp}, 0);
    resync   = 1'b0;
    div_load = 1'b0;
    for (int k = 3; k <= 30; k += 3) q1.push_back(k);
    q2.push_back(6);  q2.push_back(18); q2.push_back(30);
    q3.push_back(6);  q3.push_back(12); q3.push_back(18);
    q3.push_back(24); q3.push_back(30);
    watch(B_OS, B_CP, B_NC, 31, "basic");

    // resync while new_clk high
    chk("pre_resync_nc", {31'd0, b_nc}, 1);
    resync = 1'b1;
    step();
    chk("resync_nc", {31'd0, b_nc}, 0);
    resync = 1'b0;
    q1.push_back(3); q1.push_back(6);
    q2.push_back(6);
    q3.push_back(6);
    watch(B_OS, B_CP, B_NC, 7, "resync");

    // mid-period reload: D=9, reach ph=2 and cnt=5, then load D=3
    div_in_b = 8'd9;
    resync   = 1'b1;
    div_load = 1'b1;
    step();
    resync   = 1'b0;
    div_load = 1'b0;
    q1.push_back(10); q1.push_back(20);
    q2.push_back(20);
    q3.push_back(20);
    watch(B_OS, B_CP, B_NC, 25, "d9");
    div_in_b = 8'd3;
    div_load = 1'b1;
    step();
    chk("reload_nc_held", {31'd0, b_nc}, 1);
    chk("reload_os", {31'd0, b_os}, 0);
    div_load = 1'b0;
    q1.push_back(4); q1.push_back(8); q1.push_back(12); q1.push_back(16);
    q2.push_back(16);
    q3.push_back(8); q3.push_back(16);
    watch(B_OS, B_CP, B_NC, 17, "reload");

    // enable low clears outputs; re-enable restarts at phase 0 with D retained
    enable = 1'b0;
    q3.push_back(1);
    watch(B_OS, B_CP, B_NC, 6, "disabled");
    chk("disabled_os", {31'd0, b_os}, 0);
    chk("disabled_cp", {31'd0, b_cp}, 0);
    enable = 1'b1;
    q1.push_back(4); q1.push_back(8);
    q2.push_back(8);
    q3.push_back(8);
    watch(B_OS, B_CP, B_NC, 9, "reenable");

    // D=0: tick every cycle
    div_in_b = 8'd0;
    resync   = 1'b1;
    div_load = 1'b1;
    step();
    resync   = 1'b0;
    div_load = 1'b0;
    for (int k = 1; k <= 9; k++) q1.push_back(k);
    q2.push_back(2); q2.push_back(6);
    q3.push_back(2); q3.push_back(4); q3.push_back(6); q3.push_back(8);
    watch(B_OS, B_CP, B_NC, 9, "d0");

    // maximum divisor on WIDTH=4, OVERSAMPLE=2
    div_in_c = 4'd15;
    resync   = 1'b1;
    div_load = 1'b1;
    step();
    resync   = 1'b0;
    div_load = 1'b0;
    q1.push_back(16); q1.push_back(32); q1.push_back(48);
    q2.push_back(16); q2.push_back(48);
    q3.push_back(16); q3.push_back(32); q3.push_back(48);
    watch(C_OS, C_CP, C_NC, 50, "dmax");

    // reset mid-run overrides a concurrent load and restores DEFAULT_DIV
    n = int'($urandom_range(3, 20));
    repeat (n) step();
    rst_n    = 1'b0;
    div_load = 1'b1;
    div_in_b = 8'd7;
    step();
    chk_all_zero("midrst");
    rst_n    = 1'b1;
    div_load = 1'b0;
    div_in_b = 8'd2;
    q1.push_back(3); q1.push_back(6);
    watch(B_OS, S_NONE, S_NONE, 7, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
# baud_gen

Runtime-programmable clock/baud generator, successor to the fixed power-of-two divider. It divides `clk` by a loadable integer divisor into an oversample tick, then by a power-of-two oversample factor into a ~50% duty `new_clk` with a one-cycle rising-edge pulse. It sits between the system clock and the UART/ULPI serial front-ends, which consume `os_pulse` for mid-bit sampling and `clk_pulse` for bit timing.

## Interface
- `WIDTH`, 16: width of the divisor register and prescaler counter.
- `OVERSAMPLE`, 16: oversample ticks per output period; power of two, ≥2.
- `DEFAULT_DIV`, 0x0067: divisor value loaded at reset.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  run when high; when low, all counters are cleared and the divisor is retained.
- `div_in`  in  WIDTH  new divisor value D.
- `div_load`  in  1  loads `div_in` into D on this edge.
- `resync`  in  1  restarts the phase (prescaler and phase counter cleared).
- `os_pulse`  out  1  one-cycle tick, one every D+1 cycles.
- `new_clk`  out  1  divided clock with period OVERSAMPLE·(D+1) cycles.
- `clk_pulse`  out  1  one-cycle pulse on the cycle `new_clk` first reads 1.

## Operation
- State:
  - divisor register D (WIDTH bits);
  - prescaler `cnt` (WIDTH bits);
  - phase counter `ph` (log2(OVERSAMPLE) bits);
  - registered outputs `os_pulse`, `new_clk`, `clk_pulse`.
- Priority on each edge: `!rst_n` > `resync` > `div_load` > `!enable` > count.
- Reset:
  - D = DEFAULT_DIV;
  - `cnt`, `ph` = 0;
  - `os_pulse`, `new_clk`, `clk_pulse` = 0.
- Resync: `cnt`, `ph`, and all three outputs are cleared. If `div_load` is also high, D is still loaded on the same edge.
- Load:
  - D ← `div_in`; `cnt` ← 0; `os_pulse` and `clk_pulse` ← 0.
  - `ph` and `new_clk` hold.
  - Load is honoured regardless of `enable`.
- Enable low: `cnt` and `ph` cleared; all outputs 0; D held.
- Count (enable high):
  - If `cnt` == D: `cnt` ← 0, `os_pulse` ← 1, `ph` ← `ph`+1 (wraps at OVERSAMPLE).
  - Otherwise: `cnt` ← `cnt`+1, `os_pulse` ← 0.
- `new_clk` ← (`ph_next` ≥ OVERSAMPLE/2). It is updated only on tick edges and held otherwise.
- `clk_pulse` ← tick & (`ph_next` == OVERSAMPLE/2); it is 0 on every other edge.
- D = 0 is legal: `os_pulse` is high every cycle while enabled.
- D = 2^WIDTH−1: the prescaler reaches its maximum and wraps to 0 on match, never by overflow.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- First `os_pulse` is visible after D+1 enabled edges, counted from the first edge with `enable` high and `cnt` = 0.
- `os_pulse` spacing: exactly D+1 cycles.
- `clk_pulse` spacing: OVERSAMPLE·(D+1) cycles.
- `new_clk` duty: high for (OVERSAMPLE/2)·(D+1) cycles, low for the same.
- First `clk_pulse` occurs (OVERSAMPLE/2)·(D+1) cycles after enable.
- `div_load` mid-period: the new D governs the very next tick, which lands D_new+1 cycles after the load edge. Phase is preserved, so no glitch appears on `new_clk`.
- `enable` dropped mid-period: outputs read 0 after that edge. Re-enable restarts from phase 0.
- `rst_n` low mid-operation: all state takes reset values after that edge, independent of other inputs.

## Structure
- Shared package `baud_gen_pkg`:
  - default constants (`DEFAULT_WIDTH`, `DEFAULT_OVERSAMPLE`, `DEFAULT_DIV`);
  - a `clog2` function for the `ph` width;
  - common baud divisor constants for 12 MHz (115200 → 6 at OVERSAMPLE=16; 9600 → 77).
- One sub-module, `baud_prescaler`: D register, `cnt`, and tick generation, including load and clear. The top level holds `ph`, `new_clk`, and `clk_pulse`.
- Elaboration check: OVERSAMPLE must be a power of two and ≥2.

## Test plan
- Reset and default: hold `rst_n`=0 for 3 cycles, then `enable`=1 with DEFAULT_DIV and WIDTH=16 → all outputs 0 during reset; `os_pulse` every 104 cycles.
- Basic divide: WIDTH=8, OVERSAMPLE=4, load D=2, `enable`=1 →
  - `os_pulse` at enabled edges 3, 6, 9, 12, …;
  - `new_clk` high from edge 6 to edge 12 (6 cycles high, 6 low);
  - `clk_pulse` at edges 6, 18, 30.
- D=0: OVERSAMPLE=4 → `os_pulse` constant 1; `new_clk` toggles every 2 cycles; `clk_pulse` every 4 cycles.
- Mid-period reload: D=9 running; load D=3 at cnt=5 → next `os_pulse` 4 cycles after the load edge; `ph` and `new_clk` unchanged across the load.
- Resync and enable: `resync` pulsed while `new_clk`=1 → `new_clk`=0 next cycle, and the next `clk_pulse` is (OVERSAMPLE/2)·(D+1) cycles later. Drop `enable` → all outputs 0 while D is retained. `resync`+`div_load` on the same edge → D loaded and counters cleared.
- Maximum divisor: WIDTH=4, D=15 → `os_pulse` every 16 cycles with no counter overflow. Random `rst_n` mid-run → all outputs 0 on the next cycle.
